pipelined_csa_addsub: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on input and output. It generalises the fixed 16-bit, 4-bit-block carry-select adder to any width, block size and pipeline depth. It adds subtract mode, carry-in, and signed-overflow and zero flags. It is the arithmetic core for the datapath labs and sits between operand registers and the result bus, accepting one operation per cycle.

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_block.sv | 60 ++++++
 rtl/pipelined_csa_addsub.sv | 155 +++++++++++++++
 tb/tb_pipelined_csa_addsub.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and parameter checks for the carry-select adder/subtractor
package csa_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // True when the width splits into whole blocks and the blocks split evenly over the stages.
    function automatic bit csa_params_ok(input int width, input int blk, input int stages);
        if (blk < 1 || width < blk) return 1'b0;
        if ((width % blk) != 0) return 1'b0;
        if (stages < 1 || stages > (width / blk)) return 1'b0;
        return ((width / blk) % stages) == 0;
    endfunction

endpackage

// File: rtl/csa_block.sv
// rtl/csa_block.sv - one carry-select block: dual ripple chains plus carry select
// Ports:
//   a, b   : block operand slices (b already inverted for subtract)
//   cin    : carry into the block
//   sum    : block sum bits
//   cout   : carry out of the block MSB
//   c_msb  : carry into the block MSB (used for signed overflow on the top block)
// SELECT=0 builds a single ripple chain fed directly by cin (used for block 0).
module csa_block
    import csa_pkg::*;
#(
    parameter int BLK    = 4,
    parameter bit SELECT = 1'b1
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [BLK-1:0] s0;
    logic [BLK:0]   c0;

    // In select mode this is the carry-in-0 chain; otherwise it rides the real carry.
    always_comb begin
        s0    = '0;
        c0    = '0;
        c0[0] = SELECT ? 1'b0 : cin;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
        end
    end

    if (SELECT) begin : g_select
        logic [BLK-1:0] s1;
        logic [BLK:0]   c1;

        always_comb begin
            s1    = '0;
            c1    = '0;
            c1[0] = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                s1[i]   = a[i] ^ b[i] ^ c1[i];
                c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
            end
        end

        assign sum   = cin ? s1 : s0;
        assign cout  = cin ? c1[BLK] : c0[BLK];
        assign c_msb = cin ? c1[BLK-1] : c0[BLK-1];
    end else begin : g_ripple
        assign sum   = s0;
        assign cout  = c0[BLK];
        assign c_msb = c0[BLK-1];
    end

endmodule

// File: rtl/pipelined_csa_addsub.sv
// rtl/pipelined_csa_addsub.sv - pipelined carry-select adder/subtractor with valid/ready handshakes
// Ports:
//   Clk, Reset_n                 : clock, asynchronous active-low reset
//   in_valid, in_ready           : operation handshake (in_ready is combinational)
//   A, B, Cin, Op                : operands, carry-in (add only), 0=add 1=subtract
//   out_valid, out_ready         : result handshake
//   Sum, CO, OVF, Z              : registered result, carry out, signed overflow, zero
// Blocks are spread evenly over STAGES register stages; the whole pipe stalls together.
module pipelined_csa_addsub
    import csa_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             OVF,
    output logic             Z
);

    localparam int NBLK = WIDTH / BLK;
    localparam int BPS  = NBLK / STAGES;

    if (!csa_params_ok(WIDTH, BLK, STAGES)) begin : g_param_check
        $error("pipelined_csa_addsub: illegal WIDTH/BLK/STAGES combination");
    end

    // Stage registers. Operands travel whole; each stage only reads the slices of its own blocks.
    logic [WIDTH-1:0] st_sum [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic             st_c   [STAGES];
    logic             st_v   [STAGES];
    logic             ovf_q;
    logic             z_q;

    // Per-stage combinational inputs (stage 0 from the ports, others from the previous register).
    logic [WIDTH-1:0] in_sum [STAGES];
    logic [WIDTH-1:0] in_a   [STAGES];
    logic [WIDTH-1:0] in_b   [STAGES];
    logic             in_c   [STAGES];
    logic             in_v   [STAGES];

    logic [WIDTH-1:0] nxt_sum [STAGES];
    logic             nxt_c   [STAGES];
    logic             nxt_ovf;
    logic             nxt_z;

    logic [BLK-1:0]   blk_sum  [NBLK];
    logic             blk_cout [NBLK];
    logic             blk_cmsb [NBLK];

    logic             advance;

    assign out_valid = st_v[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    assign Sum = st_sum[STAGES-1];
    assign CO  = st_c[STAGES-1];
    assign OVF = ovf_q;
    assign Z   = z_q;

    always_comb begin : stage_inputs
        // Subtract is A + ~B + 1, so the inversion and forced carry happen before stage 0.
        in_a[0]   = A;
        in_b[0]   = (op_e'(Op) == OP_SUB) ? ~B : B;
        in_c[0]   = (op_e'(Op) == OP_SUB) ? 1'b1 : Cin;
        in_sum[0] = '0;
        in_v[0]   = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            in_a[s]   = st_a[s-1];
            in_b[s]   = st_b[s-1];
            in_c[s]   = st_c[s-1];
            in_sum[s] = st_sum[s-1];
            in_v[s]   = st_v[s-1];
        end
    end

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int S = i / BPS;
        logic cin;
        logic cout;

        // The first block of each stage takes the carry registered by the previous stage.
        if ((i % BPS) == 0) begin : g_head
            assign cin = in_c[S];
        end else begin : g_link
            assign cin = g_blk[i-1].cout;
        end

        csa_block #(
            .BLK    (BLK),
            .SELECT (i != 0)
        ) u_blk (
            .a     (in_a[S][i*BLK +: BLK]),
            .b     (in_b[S][i*BLK +: BLK]),
            .cin   (cin),
            .sum   (blk_sum[i]),
            .cout  (cout),
            .c_msb (blk_cmsb[i])
        );

        assign blk_cout[i] = cout;
    end

    always_comb begin : stage_results
        for (int s = 0; s < STAGES; s++) begin
            nxt_sum[s] = in_sum[s];
            for (int j = 0; j < BPS; j++) begin
                nxt_sum[s][(s*BPS + j)*BLK +: BLK] = blk_sum[s*BPS + j];
            end
            nxt_c[s] = blk_cout[s*BPS + BPS - 1];
        end
        // Only the final stage's values of these reach the flag registers.
        nxt_ovf = blk_cmsb[NBLK-1] ^ blk_cout[NBLK-1];
        nxt_z   = (nxt_sum[STAGES-1] == '0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                st_v[s]   <= 1'b0;
                st_c[s]   <= 1'b0;
                st_sum[s] <= '0;
                st_a[s]   <= '0;
                st_b[s]   <= '0;
            end
            ovf_q <= 1'b0;
            z_q   <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                st_v[s]   <= in_v[s];
                st_c[s]   <= nxt_c[s];
                st_sum[s] <= nxt_sum[s];
                st_a[s]   <= in_a[s];
                st_b[s]   <= in_b[s];
            end
            ovf_q <= nxt_ovf;
            z_q   <= nxt_z;
        end
    end

endmodule

// File: tb/tb_pipelined_csa_addsub.sv
// tb/tb_pipelined_csa_addsub.sv - self-checking bench for pipelined_csa_addsub (16/4/2 and 32/8/4)
module tb_pipelined_csa_addsub;

    logic clk;
    logic rst_n;

    logic        iv16, ir16, ov16, or16, cin16, op16, co16, ovf16, z16;
    logic [15:0] a16, b16, sum16;
    logic        iv32, ir32, ov32, or32, cin32, op32, co32, ovf32, z32;
    logic [31:0] a32, b32, sum32;

    int total = 0;
    int bad   = 0;

    logic [15:0] bp_vals [$];
    int          bp_cyc  [$];

    pipelined_csa_addsub d16 (
        .Clk(clk), .Reset_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16), .Cin(cin16), .Op(op16),
        .out_valid(ov16), .out_ready(or16), .Sum(sum16), .CO(co16), .OVF(ovf16), .Z(z16)
    );

    pipelined_csa_addsub #(.WIDTH(32), .BLK(8), .STAGES(4)) d32 (
        .Clk(clk), .Reset_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32), .Cin(cin32), .Op(op32),
        .out_valid(ov32), .out_ready(or32), .Sum(sum32), .CO(co32), .OVF(ovf32), .Z(z32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow judged by the signed result leaving range.
    function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic op);
        longint lim, ua, ub, sa, sb, r, sr;
        logic [31:0] s;
        logic co, ovf;
        lim = longint'(1) << (w - 1);
        ua  = longint'(a);
        ub  = longint'(b);
        if (op) r = ua - ub + 2*lim;
        else    r = ua + ub + longint'(cin);
        co  = (r >= 2*lim);
        s   = 32'(r % (2*lim));
        sa  = (ua >= lim) ? ua - 2*lim : ua;
        sb  = (ub >= lim) ? ub - 2*lim : ub;
        sr  = op ? (sa - sb) : (sa + sb + longint'(cin));
        ovf = (sr >= lim) || (sr < -lim);
        return {co, ovf, (s == 32'd0), s};
    endfunction

    task automatic dir16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic op, input logic [15:0] es,
                         input logic eco, input logic eovf, input logic ez);
        @(posedge clk); #1;
        a16 = a; b16 = b; cin16 = cin; op16 = op; iv16 = 1'b1; or16 = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, ir16, 1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = ~cin; op16 = ~op;
        @(negedge clk);
        chk({tag, "_early"}, ov16, 0);
        @(negedge clk);
        chk({tag, "_valid"}, ov16, 1);
        chk({tag, "_sum"}, sum16, es);
        chk({tag, "_co"}, co16, eco);
        chk({tag, "_ovf"}, ovf16, eovf);
        chk({tag, "_z"}, z16, ez);
        @(negedge clk);
        chk({tag, "_once"}, ov16, 0);
    endtask

    task automatic rnd16(input int n);
        int sent = 0, recvd = 0, cyc = 0;
        logic [34:0] q [$];
        logic [34:0] e;
        while (recvd < n && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            iv16  = (sent < n) && ($urandom_range(3) != 0);
            a16   = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom_range(1)); op16 = 1'($urandom_range(1));
            case ($urandom_range(15))
                0: a16 = 16'h0000;
                1: a16 = 16'hFFFF;
                2: a16 = 16'h8000;
                3: b16 = a16;
                default: ;
            endcase
            or16 = 1'($urandom_range(1));
            @(negedge clk);
            if (ov16 && or16) begin
                chk("r16_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("r16_result", {co16, ovf16, z16, 16'h0000, sum16}, e);
                end
                recvd++;
            end
            if (iv16 && ir16) begin
                q.push_back(model(16, {16'h0000, a16}, {16'h0000, b16}, cin16, op16));
                sent++;
            end
        end
        chk("r16_count", recvd, n);
        chk("r16_left", q.size(), 0);
    endtask

    task automatic rnd32(input int n);
        int sent = 0, recvd = 0, cyc = 0;
        logic [34:0] q [$];
        logic [34:0] e;
        while (recvd < n && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            iv32  = (sent < n) && ($urandom_range(3) != 0);
            a32   = $urandom; b32 = $urandom;
            cin32 = 1'($urandom_range(1)); op32 = 1'($urandom_range(1));
            case ($urandom_range(15))
                0: a32 = 32'h0000_0000;
                1: a32 = 32'hFFFF_FFFF;
                2: a32 = 32'h8000_0000;
                3: b32 = a32;
                4: begin a32 = 32'h7FFF_FFFF; b32 = 32'h0; end
                default: ;
            endcase
            or32 = 1'($urandom_range(1));
            @(negedge clk);
            if (ov32 && or32) begin
                chk("r32_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("r32_result", {co32, ovf32, z32, sum32}, e);
                end
                recvd++;
            end
            if (iv32 && ir32) begin
                q.push_back(model(32, a32, b32, cin32, op32));
                sent++;
            end
        end
        chk("r32_count", recvd, n);
        chk("r32_left", q.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int stale;
        rst_n = 1'b0;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; op16 = 1'b0;
        iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; op32 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov16", ov16, 0);
        chk("rst_sum16", sum16, 0);
        chk("rst_flags16", {co16, ovf16, z16}, 0);
        chk("rst_ov32", ov32, 0);
        chk("rst_sum32", sum32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ir16", ir16, 1);
        chk("rst_ir32", ir32, 1);

        dir16("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        dir16("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        dir16("sub_borrow",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        dir16("add_ripple",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        dir16("sub_cin_ign", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

        // Backpressure: four adds, out_ready low for the first five cycles of the window.
        idx = 0;
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            #1;
            if (idx < 4) begin
                a16 = 16'(idx + 1); b16 = 16'(idx + 1); cin16 = 1'b0; op16 = 1'b0; iv16 = 1'b1;
            end else begin
                iv16 = 1'b0;
            end
            or16 = (c >= 5);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                chk("bp_hold_valid", ov16, 1);
                chk("bp_hold_sum", sum16, 16'd2);
                chk("bp_in_ready", ir16, 0);
            end
            if (iv16 && ir16) idx++;
            if (ov16 && or16) begin
                bp_vals.push_back(sum16);
                bp_cyc.push_back(c);
            end
            @(posedge clk);
        end
        chk("bp_count", bp_vals.size(), 4);
        for (int i = 0; i < bp_vals.size(); i++) begin
            chk("bp_value", bp_vals[i], 64'(2 * (i + 1)));
            chk("bp_no_gap", bp_cyc[i] - bp_cyc[0], i);
        end

        // Reset with two operations in flight; the older one is already on the output.
        #1;
        a16 = 16'd7; b16 = 16'd1; cin16 = 1'b0; op16 = 1'b0; iv16 = 1'b1; or16 = 1'b0;
        @(posedge clk); #1;
        a16 = 16'd3; b16 = 16'd3;
        @(posedge clk); #1;
        iv16 = 1'b0;
        chk("mid_pre_valid", ov16, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov16, 0);
        chk("mid_rst_sum", sum16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        or16 = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (ov16) stale++;
        end
        chk("mid_no_stale", stale, 0);
        dir16("after_rst", 16'd5, 16'd5, 1'b0, 1'b0, 16'd10, 1'b0, 1'b0, 1'b0);

        fork
            rnd16(3000);
            rnd32(10000);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
